// File: rtl/bidir_pkg.sv
// Shared types for the half-duplex bidirectional bus controller.
package bidir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2,
    SAMPLE = 2'd3
  } state_e;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bidir_pad.sv
// Tristate pad wrapper; the only driver of the shared bidirectional net.
module bidir_pad #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0] bidir
);

  assign bidir = oe ? dout : {WIDTH{1'bz}};
  assign din   = bidir;

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex pad controller: round-robin TX/RX arbitration with turnaround
// cycles inserted on every direction change.
module bidir_bus_ctrl
  import bidir_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TURN_CYC   = 1,
  parameter int DRIVE_CYC  = 2,
  parameter int SAMPLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_req,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ack,
  input  logic             rx_req,
  output logic             rx_ack,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             oe,
  output logic             busy,
  inout  wire  [WIDTH-1:0] bidir
);

  localparam int CW = $clog2(max3(TURN_CYC, DRIVE_CYC, SAMPLE_CYC)) + 1;
  localparam logic [CW-1:0] TURN_LD   = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] DRIVE_LD  = CW'(DRIVE_CYC - 1);
  localparam logic [CW-1:0] SAMPLE_LD = CW'(SAMPLE_CYC - 1);

  state_e           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             cur_dir_r, cur_dir_s;
  logic             last_grant_r, last_grant_s;
  logic [WIDTH-1:0] hold_r, hold_s;
  logic             oe_r, oe_s;
  logic [WIDTH-1:0] rx_data_r;
  logic             rx_valid_r;
  logic [WIDTH-1:0] din_s;
  logic             cnt_zero_s;
  logic             grant_tx_s;

  assign cnt_zero_s = (cnt_r == {CW{1'b0}});
  // Round robin: TX wins a conflict only if RX had the previous grant.
  assign grant_tx_s = tx_req && (!rx_req || (last_grant_r == DIR_RX));

  // Next-state, counter reload and hold-register capture.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    cur_dir_s    = cur_dir_r;
    last_grant_s = last_grant_r;
    hold_s       = hold_r;
    case (state_r)
      IDLE: begin
        if (grant_tx_s) begin
          hold_s       = tx_data;
          last_grant_s = DIR_TX;
          if (cur_dir_r == DIR_TX) begin
            state_s = DRIVE;
            cnt_s   = DRIVE_LD;
          end else begin
            state_s   = TURN;
            cnt_s     = TURN_LD;
            cur_dir_s = DIR_TX;
          end
        end else if (rx_req) begin
          last_grant_s = DIR_RX;
          if (cur_dir_r == DIR_RX) begin
            state_s = SAMPLE;
            cnt_s   = SAMPLE_LD;
          end else begin
            state_s   = TURN;
            cnt_s     = TURN_LD;
            cur_dir_s = DIR_RX;
          end
        end else begin
          state_s = IDLE;
        end
      end
      TURN: begin
        if (!cnt_zero_s) begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else if (cur_dir_r == DIR_TX) begin
          state_s = DRIVE;
          cnt_s   = DRIVE_LD;
        end else begin
          state_s = SAMPLE;
          cnt_s   = SAMPLE_LD;
        end
      end
      DRIVE, SAMPLE: begin
        if (cnt_zero_s) begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output enable follows the next state; IDLE parks the previous value.
  always_comb begin
    case (state_s)
      DRIVE:   oe_s = 1'b1;
      IDLE:    oe_s = oe_r;
      default: oe_s = 1'b0;
    endcase
  end

  // State, direction, hold and receive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      cur_dir_r    <= DIR_RX;
      last_grant_r <= DIR_RX;
      hold_r       <= {WIDTH{1'b0}};
      oe_r         <= 1'b0;
      rx_data_r    <= {WIDTH{1'b0}};
      rx_valid_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      cur_dir_r    <= cur_dir_s;
      last_grant_r <= last_grant_s;
      hold_r       <= hold_s;
      oe_r         <= oe_s;
      rx_valid_r   <= (state_r == SAMPLE) && cnt_zero_s;
      if ((state_r == SAMPLE) && cnt_zero_s) begin
        rx_data_r <= din_s;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign tx_ack   = (state_r == DRIVE) && cnt_zero_s;
  assign rx_ack   = (state_r == SAMPLE) && cnt_zero_s;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign oe       = oe_r;
  assign busy     = (state_r != IDLE);

  bidir_pad #(.WIDTH(WIDTH)) u_pad (
    .oe    (oe_r),
    .dout  (hold_r),
    .din   (din_s),
    .bidir (bidir)
  );

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl: default build plus a TURN_CYC=3/DRIVE_CYC=1 build.
module tb_bidir_bus_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tx_req, rx_req;
  logic [7:0] tx_data;
  logic       tx_ack, rx_ack, rx_valid, oe, busy;
  logic [7:0] rx_data;
  wire  [7:0] bidir;
  logic       tb_drv_en;
  logic [7:0] tb_drv_val;

  logic       tx_req2, rx_req2;
  logic [7:0] tx_data2;
  logic       tx_ack2, rx_ack2, rx_valid2, oe2, busy2;
  logic [7:0] rx_data2;
  wire  [7:0] bidir2;

  int n_checks;
  int n_errors;

  logic [3:0] arb_exp [16];

  // Far-end driver; only drives while the controller has released the pad.
  assign bidir = (tb_drv_en && !oe) ? tb_drv_val : 8'bzzzz_zzzz;

  bidir_bus_ctrl #(.WIDTH(8), .TURN_CYC(1), .DRIVE_CYC(2), .SAMPLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_req(rx_req), .rx_ack(rx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
    .oe(oe), .busy(busy), .bidir(bidir)
  );

  bidir_bus_ctrl #(.WIDTH(8), .TURN_CYC(3), .DRIVE_CYC(1), .SAMPLE_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_req(tx_req2), .tx_data(tx_data2), .tx_ack(tx_ack2),
    .rx_req(rx_req2), .rx_ack(rx_ack2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .oe(oe2), .busy(busy2), .bidir(bidir2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // {busy, oe, tx_ack, rx_ack} per cycle with both requests held high
    arb_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b0100,
                4'b1000, 4'b1000, 4'b1001, 4'b0000,
                4'b1000, 4'b1100, 4'b1110, 4'b0100,
                4'b1000, 4'b1000, 4'b1001, 4'b0000};
    rst_n = 1'b0;
    tx_req = 1'b0; rx_req = 1'b0; tx_data = 8'h00;
    tx_req2 = 1'b0; rx_req2 = 1'b0; tx_data2 = 8'h00;
    tb_drv_en = 1'b0; tb_drv_val = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_ack", {31'd0, tx_ack}, 32'd0);
    check("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_oe2", {31'd0, oe2}, 32'd0);

    // First TX after reset: one TURN, two DRIVE, then parked
    tx_req = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    check("t1_turn_busy", {31'd0, busy}, 32'd1);
    check("t1_turn_oe", {31'd0, oe}, 32'd0);
    tx_data = 8'hFF;
    @(negedge clk);
    check("t1_d1_oe", {31'd0, oe}, 32'd1);
    check("t1_d1_bus", {24'd0, bidir}, 32'h A5);
    check("t1_d1_ack", {31'd0, tx_ack}, 32'd0);
    @(negedge clk);
    check("t1_d2_bus", {24'd0, bidir}, 32'hA5);
    check("t1_d2_ack", {31'd0, tx_ack}, 32'd1);
    tx_req = 1'b0;
    @(negedge clk);
    check("t1_park_busy", {31'd0, busy}, 32'd0);
    check("t1_park_oe", {31'd0, oe}, 32'd1);
    check("t1_park_bus", {24'd0, bidir}, 32'hA5);
    check("t1_park_ack", {31'd0, tx_ack}, 32'd0);

    // Back-to-back TX, same direction: no TURN
    tx_req = 1'b1; tx_data = 8'h01;
    @(negedge clk);
    check("t2_a1_busy", {31'd0, busy}, 32'd1);
    check("t2_a1_bus", {24'd0, bidir}, 32'h01);
    check("t2_a1_ack", {31'd0, tx_ack}, 32'd0);
    @(negedge clk);
    check("t2_a2_bus", {24'd0, bidir}, 32'h01);
    check("t2_a2_ack", {31'd0, tx_ack}, 32'd1);
    tx_data = 8'h02;
    @(negedge clk);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("t2_b1_bus", {24'd0, bidir}, 32'h02);
    check("t2_b1_oe", {31'd0, oe}, 32'd1);
    check("t2_b1_ack", {31'd0, tx_ack}, 32'd0);
    @(negedge clk);
    check("t2_b2_bus", {24'd0, bidir}, 32'h02);
    check("t2_b2_ack", {31'd0, tx_ack}, 32'd1);
    tx_req = 1'b0;
    @(negedge clk);
    check("t2_end_busy", {31'd0, busy}, 32'd0);

    // RX after TX: TURN, two SAMPLE, then rx_valid
    rx_req = 1'b1; tb_drv_en = 1'b1; tb_drv_val = 8'h3C;
    @(negedge clk);
    check("t3_turn_oe", {31'd0, oe}, 32'd0);
    check("t3_turn_busy", {31'd0, busy}, 32'd1);
    check("t3_turn_ack", {31'd0, rx_ack}, 32'd0);
    @(negedge clk);
    check("t3_s1_oe", {31'd0, oe}, 32'd0);
    check("t3_s1_ack", {31'd0, rx_ack}, 32'd0);
    @(negedge clk);
    check("t3_s2_ack", {31'd0, rx_ack}, 32'd1);
    check("t3_s2_valid", {31'd0, rx_valid}, 32'd0);
    rx_req = 1'b0;
    @(negedge clk);
    check("t3_valid", {31'd0, rx_valid}, 32'd1);
    check("t3_data", {24'd0, rx_data}, 32'h3C);
    check("t3_idle_oe", {31'd0, oe}, 32'd0);
    @(negedge clk);
    check("t3_valid_drop", {31'd0, rx_valid}, 32'd0);
    check("t3_data_hold", {24'd0, rx_data}, 32'h3C);

    // Both requests held: grants alternate TX, RX, TX, RX
    tb_drv_val = 8'h5A; tx_data = 8'hC3; tx_req = 1'b1; rx_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("t4_cyc%0d", i), {28'd0, busy, oe, tx_ack, rx_ack}, {28'd0, arb_exp[i]});
      if (oe) check($sformatf("t4_bus%0d", i), {24'd0, bidir}, 32'hC3);
      if (i == 7) begin
        check("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("t4_rx_data", {24'd0, rx_data}, 32'h5A);
      end
      if (i == 14) begin
        tx_req = 1'b0; rx_req = 1'b0;
      end
    end

    // Reset during the first DRIVE cycle
    tx_req = 1'b1; tx_data = 8'h77;
    @(negedge clk);
    check("t5_turn_oe", {31'd0, oe}, 32'd0);
    @(negedge clk);
    check("t5_d1_oe", {31'd0, oe}, 32'd1);
    check("t5_d1_bus", {24'd0, bidir}, 32'h77);
    rst_n = 1'b0; tx_req = 1'b0;
    #1;
    check("t5_rst_oe", {31'd0, oe}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_ack", {31'd0, tx_ack}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_busy", {31'd0, busy}, 32'd0);
    check("t5_post_oe", {31'd0, oe}, 32'd0);
    check("t5_post_ack", {31'd0, tx_ack}, 32'd0);
    check("t5_post_rxd", {24'd0, rx_data}, 32'd0);
    rx_req = 1'b1; tb_drv_val = 8'h99;
    @(negedge clk);
    check("t5_s1_busy", {31'd0, busy}, 32'd1);
    check("t5_s1_ack", {31'd0, rx_ack}, 32'd0);
    @(negedge clk);
    check("t5_s2_ack", {31'd0, rx_ack}, 32'd1);
    rx_req = 1'b0;
    @(negedge clk);
    check("t5_valid", {31'd0, rx_valid}, 32'd1);
    check("t5_data", {24'd0, rx_data}, 32'h99);

    // TURN_CYC=3, DRIVE_CYC=1 build
    tx_req2 = 1'b1; tx_data2 = 8'h5C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_turn%0d", i), {29'd0, busy2, oe2, tx_ack2}, 32'b100);
    end
    @(negedge clk);
    check("t6_drive", {29'd0, busy2, oe2, tx_ack2}, 32'b111);
    check("t6_drive_bus", {24'd0, bidir2}, 32'h5C);
    tx_req2 = 1'b0;
    @(negedge clk);
    check("t6_park", {29'd0, busy2, oe2, tx_ack2}, 32'b010);
    check("t6_park_bus", {24'd0, bidir2}, 32'h5C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
- Half-duplex controller for a shared WIDTH-bit bidirectional pad.
- Arbitrates between a local transmit requester (drive the pad) and a local receive requester (sample the pad). Round-robin on conflict.
- Sequences the output enable and inserts turnaround cycles on every direction change, so the pad is never driven while the far end may still be driving.
- Sits directly between the core logic and the tristate pad.

Parameters:
- WIDTH, 8, pad and data width.
- TURN_CYC, 1, bus-released cycles inserted on each direction change (legal range >=1).
- DRIVE_CYC, 2, cycles the pad is actively driven per transmit (>=1).
- SAMPLE_CYC, 2, settle/sample cycles per receive; pad captured on the last one (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_req  input  1  transmit request; hold high until tx_ack.
- tx_data  input  WIDTH  transmit word; captured on grant.
- tx_ack  output  1  high during the last DRIVE cycle.
- rx_req  input  1  receive request; hold high until rx_ack.
- rx_ack  output  1  high during the last SAMPLE cycle.
- rx_data  output  WIDTH  last sampled word (registered).
- rx_valid  output  1  one-cycle pulse, aligned with new rx_data.
- oe  output  1  pad output enable (registered).
- busy  output  1  state != IDLE.
- bidir  inout  WIDTH  pad; driven with the hold register when oe=1, else high-Z.

Behaviour:
Reset:
- State IDLE, cur_dir=RX, last_grant=RX, oe=0, bidir=Z.
- tx_ack=0, rx_ack=0, rx_valid=0, rx_data=0, hold register=0, counter=0.
- Asserting rst_n low mid-operation releases the pad immediately. Any in-flight transfer is discarded with no ack and no rx_valid.

States:
- IDLE:
  - Grant TX if tx_req && (!rx_req || last_grant==RX).
  - Else grant RX if rx_req.
  - Else stay in IDLE. oe keeps its value (parking): after TX the bus stays driven with the last word.
  - On a TX grant, tx_data is latched into the hold register and last_grant=TX. On an RX grant, last_grant=RX.
  - If the granted dir equals cur_dir, go to DRIVE/SAMPLE directly. Otherwise go to TURN.
- TURN:
  - oe=0 for TURN_CYC cycles, then go to DRIVE or SAMPLE.
  - cur_dir updates on entry to TURN.
- DRIVE:
  - oe=1, bidir=hold, for DRIVE_CYC cycles.
  - tx_ack=1 in the last cycle only; next state IDLE.
- SAMPLE:
  - oe=0 for SAMPLE_CYC cycles.
  - rx_ack=1 in the last cycle. bidir is registered into rx_data at the end of that cycle.
  - rx_valid=1 for exactly one cycle after that (first IDLE cycle). Next state IDLE.

Timing rules:
- tx_ack and rx_ack are decoded from the state and counter registers only (no input paths). This lets requesters drop their request on the edge that ends the ack cycle; IDLE then sees the updated request.
- Latency from a sampled request to the first DRIVE/SAMPLE cycle:
  - 1 cycle with the same direction.
  - 1+TURN_CYC cycles on a direction change.
- tx_data changes after grant are ignored. Requests arriving outside IDLE wait.
- Counter width is clog2(max(TURN_CYC,DRIVE_CYC,SAMPLE_CYC))+1 and reloads on every state entry.
- oe is never 1 in TURN or SAMPLE.
- oe goes 0->1 only after at least TURN_CYC cycles at 0 following a SAMPLE.

Decomposition:
- Package bidir_pkg: state enum (IDLE, TURN, DRIVE, SAMPLE), dir constants (DIR_RX=0, DIR_TX=1).
- Sub-module bidir_pad: WIDTH-bit tristate (bidir = oe ? dout : Z; din = bidir). This is the only place the inout is driven.

Test Plan:
- After reset, tx_req=1 with tx_data=0xA5: cycle 1 TURN (oe=0); cycles 2-3 DRIVE (oe=1, bidir=0xA5); tx_ack=1 only in cycle 3; afterwards oe stays 1 (parked at 0xA5).
- Back-to-back TX 0x01 then 0x02: no TURN between them; bidir shows 0x01,0x01,0x02,0x02; two tx_ack pulses.
- After TX, rx_req=1 while the bench drives 0x3C once oe=0: one TURN cycle with oe=0, two SAMPLE cycles, rx_ack in the second; next cycle rx_data=0x3C with a one-cycle rx_valid pulse.
- tx_req and rx_req both held high from reset: grants alternate TX, RX, TX, RX; each direction change is preceded by TURN with oe=0; no contention (bench drives only while oe=0).
- rst_n pulsed low during the first DRIVE cycle: oe=0 and bidir=Z immediately; no tx_ack; after release, state IDLE with cur_dir=RX.
- TURN_CYC=3, DRIVE_CYC=1 build: TX after reset shows exactly 3 oe=0 TURN cycles, then one DRIVE cycle carrying tx_ack.
